// File: rtl/cpu_param.sv
// cpu_param: parametrised single-cycle CPU. Each valid instruction word is
// fetched and executed in one clock. The block sits between the program ROM
// and the board switch/LED I/O.
//
// Ports:
//   clk         system clock, rising edge
//   n_reset     asynchronous active-low reset
//   data        instruction word: [DATA_W+3:DATA_W] opcode, [DATA_W-1:0] imm
//   data_valid  1 = data is the word at addr this cycle, 0 = stall
//   switch      input port, read by IN A / IN B
//   addr        ROM address (instruction pointer)
//   led         output port register
//   halted      1 while in HALT
//   carry       current carry flag
//
// State | Meaning
// ------+---------------------------------------------------------------
// RUN   | executes data when data_valid=1, holds everything otherwise
// HALT  | entered by HLT; all registers frozen, left only through n_reset
module cpu_param #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic [DATA_W+3:0] data,
    input  logic              data_valid,
    input  logic [DATA_W-1:0] switch,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] led,
    output logic              halted,
    output logic              carry
);

    if (DATA_W < 4 || DATA_W > 16 || ADDR_W > DATA_W || ADDR_W < 1) begin : g_param_check
        $error("cpu_param: DATA_W must be 4..16 and 1 <= ADDR_W <= DATA_W");
    end

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    localparam logic [3:0] OP_ADD_AI = 4'b0000;
    localparam logic [3:0] OP_MOV_AB = 4'b0001;
    localparam logic [3:0] OP_IN_A   = 4'b0010;
    localparam logic [3:0] OP_MOV_AI = 4'b0011;
    localparam logic [3:0] OP_MOV_BA = 4'b0100;
    localparam logic [3:0] OP_ADD_BI = 4'b0101;
    localparam logic [3:0] OP_IN_B   = 4'b0110;
    localparam logic [3:0] OP_MOV_BI = 4'b0111;
    localparam logic [3:0] OP_ADD_AB = 4'b1000;
    localparam logic [3:0] OP_OUT_B  = 4'b1001;
    localparam logic [3:0] OP_SUB_AI = 4'b1010;
    localparam logic [3:0] OP_OUT_I  = 4'b1011;
    localparam logic [3:0] OP_JZ     = 4'b1100;
    localparam logic [3:0] OP_HLT    = 4'b1101;
    localparam logic [3:0] OP_JNC    = 4'b1110;
    localparam logic [3:0] OP_JMP    = 4'b1111;

    state_t              state, nxt_state;
    logic [ADDR_W-1:0]   r_ip, nxt_ip;
    logic [DATA_W-1:0]   r_a, nxt_a;
    logic [DATA_W-1:0]   r_b, nxt_b;
    logic [DATA_W-1:0]   r_out, nxt_out;
    logic                r_cf, nxt_cf;
    logic                r_zf, nxt_zf;

    logic [3:0]          op;
    logic [DATA_W-1:0]   imm;
    logic [ADDR_W-1:0]   target;
    logic [ADDR_W-1:0]   ip_inc;
    logic [DATA_W:0]     sum_ai, sum_bi, sum_ab, dif_ai;

    assign op     = data[DATA_W+3:DATA_W];
    assign imm    = data[DATA_W-1:0];
    assign target = imm[ADDR_W-1:0];
    assign ip_inc = r_ip + ADDR_W'(1);

    // One extra bit on every sum: it is the carry out, or the borrow for SUB
    // (a negative difference sets the top bit).
    assign sum_ai = {1'b0, r_a} + {1'b0, imm};
    assign sum_bi = {1'b0, r_b} + {1'b0, imm};
    assign sum_ab = {1'b0, r_a} + {1'b0, r_b};
    assign dif_ai = {1'b0, r_a} - {1'b0, imm};

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state <= ST_RUN;
            r_ip  <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_out <= '0;
            r_cf  <= 1'b0;
            r_zf  <= 1'b0;
        end else begin
            state <= nxt_state;
            r_ip  <= nxt_ip;
            r_a   <= nxt_a;
            r_b   <= nxt_b;
            r_out <= nxt_out;
            r_cf  <= nxt_cf;
            r_zf  <= nxt_zf;
        end
    end

    always_comb begin
        nxt_state = state;
        nxt_ip    = r_ip;
        nxt_a     = r_a;
        nxt_b     = r_b;
        nxt_out   = r_out;
        nxt_cf    = r_cf;
        nxt_zf    = r_zf;
        if (state == ST_RUN && data_valid) begin
            nxt_ip = ip_inc;
            nxt_cf = 1'b0;
            nxt_zf = 1'b0;
            // Jump conditions use r_cf/r_zf, i.e. the flags from before this
            // instruction.
            case (op)
                OP_ADD_AI: begin
                    nxt_a  = sum_ai[DATA_W-1:0];
                    nxt_cf = sum_ai[DATA_W];
                    nxt_zf = (sum_ai[DATA_W-1:0] == '0);
                end
                OP_ADD_BI: begin
                    nxt_b  = sum_bi[DATA_W-1:0];
                    nxt_cf = sum_bi[DATA_W];
                    nxt_zf = (sum_bi[DATA_W-1:0] == '0);
                end
                OP_ADD_AB: begin
                    nxt_a  = sum_ab[DATA_W-1:0];
                    nxt_cf = sum_ab[DATA_W];
                    nxt_zf = (sum_ab[DATA_W-1:0] == '0);
                end
                OP_SUB_AI: begin
                    nxt_a  = dif_ai[DATA_W-1:0];
                    nxt_cf = dif_ai[DATA_W];
                    nxt_zf = (dif_ai[DATA_W-1:0] == '0);
                end
                OP_MOV_AI: nxt_a   = imm;
                OP_MOV_BI: nxt_b   = imm;
                OP_MOV_AB: nxt_a   = r_b;
                OP_MOV_BA: nxt_b   = r_a;
                OP_IN_A:   nxt_a   = switch;
                OP_IN_B:   nxt_b   = switch;
                OP_OUT_B:  nxt_out = r_b;
                OP_OUT_I:  nxt_out = imm;
                OP_JMP:    nxt_ip  = target;
                OP_JNC:    nxt_ip  = r_cf ? ip_inc : target;
                OP_JZ:     nxt_ip  = r_zf ? target : ip_inc;
                OP_HLT: begin
                    nxt_ip    = r_ip;
                    nxt_state = ST_HALT;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        addr   = r_ip;
        led    = r_out;
        halted = (state == ST_HALT);
        carry  = r_cf;
    end

endmodule

// File: tb/tb_cpu_param.sv
module tb_cpu_param;

    logic        clk;
    logic        n_reset;
    logic [7:0]  data4;
    logic        valid4;
    logic [3:0]  sw4;
    logic [3:0]  addr4;
    logic [3:0]  led4;
    logic        halted4;
    logic        carry4;
    logic [11:0] data8;
    logic        valid8;
    logic [7:0]  sw8;
    logic [5:0]  addr8;
    logic [7:0]  led8;
    logic        halted8;
    logic        carry8;

    cpu_param #(.DATA_W(4), .ADDR_W(4)) dut4 (
        .clk(clk), .n_reset(n_reset), .data(data4), .data_valid(valid4),
        .switch(sw4), .addr(addr4), .led(led4), .halted(halted4), .carry(carry4)
    );

    cpu_param #(.DATA_W(8), .ADDR_W(6)) dut8 (
        .clk(clk), .n_reset(n_reset), .data(data8), .data_valid(valid8),
        .switch(sw8), .addr(addr8), .led(led8), .halted(halted8), .carry(carry8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int ip;
        int led;
        int halt;
        int cf;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    int dw_of[2] = '{4, 8};
    int aw_of[2] = '{4, 6};
    int m_ip[2], m_a[2], m_b[2], m_out[2], m_cf[2], m_zf[2], m_halt[2];

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_ip[i] = 0; m_a[i] = 0; m_b[i] = 0; m_out[i] = 0;
            m_cf[i] = 0; m_zf[i] = 0; m_halt[i] = 0;
        end
    endtask

    // Behavioural ISA model: integer arithmetic with masks, one instruction.
    task automatic model_exec(input int id, input int op, input int imm_in, input int sw);
        int dm, am, imm, nip, r, ncf, nzf;
        bit arith;
        dm = (1 << dw_of[id]) - 1;
        am = (1 << aw_of[id]) - 1;
        imm = imm_in & dm;
        if (m_halt[id] != 0) return;
        nip = (m_ip[id] + 1) & am;
        arith = 0; ncf = 0; nzf = 0;
        case (op)
            0:  begin r = m_a[id] + imm;     arith = 1; ncf = (r > dm); m_a[id] = r & dm; nzf = (m_a[id] == 0); end
            5:  begin r = m_b[id] + imm;     arith = 1; ncf = (r > dm); m_b[id] = r & dm; nzf = (m_b[id] == 0); end
            8:  begin r = m_a[id] + m_b[id]; arith = 1; ncf = (r > dm); m_a[id] = r & dm; nzf = (m_a[id] == 0); end
            10: begin arith = 1; ncf = (imm > m_a[id]); m_a[id] = (m_a[id] - imm) & dm; nzf = (m_a[id] == 0); end
            3:  m_a[id] = imm;
            7:  m_b[id] = imm;
            1:  m_a[id] = m_b[id];
            4:  m_b[id] = m_a[id];
            2:  m_a[id] = sw & dm;
            6:  m_b[id] = sw & dm;
            9:  m_out[id] = m_b[id];
            11: m_out[id] = imm;
            15: nip = imm & am;
            14: if (m_cf[id] == 0) nip = imm & am;
            12: if (m_zf[id] != 0) nip = imm & am;
            13: begin nip = m_ip[id]; m_halt[id] = 1; end
            default: ;
        endcase
        m_ip[id] = nip;
        m_cf[id] = arith ? ncf : 0;
        m_zf[id] = arith ? nzf : 0;
    endtask

    // Drive one word into one core (the other core stalls), push the
    // model's expectation, clock, then pop and compare.
    task automatic step(input int id, input int op, input int imm, input bit valid, input int sw);
        exp_t e;
        if (id == 0) begin
            data4  = 8'((op << 4) | (imm & 15));
            valid4 = valid;
            sw4    = 4'(sw);
            valid8 = 1'b0;
        end else begin
            data8  = 12'((op << 8) | (imm & 255));
            valid8 = valid;
            sw8    = 8'(sw);
            valid4 = 1'b0;
        end
        if (valid) model_exec(id, op, imm, sw);
        e = '{m_ip[id], m_out[id], m_halt[id], m_cf[id]};
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (id == 0) begin
            check("ip4", int'(addr4), e.ip);
            check("led4", int'(led4), e.led);
            check("halted4", int'(halted4), e.halt);
            check("carry4", int'(carry4), e.cf);
        end else begin
            check("ip8", int'(addr8), e.ip);
            check("led8", int'(led8), e.led);
            check("halted8", int'(halted8), e.halt);
            check("carry8", int'(carry8), e.cf);
        end
    endtask

    initial begin
        n_reset = 1'b0;
        data4 = '0; valid4 = 1'b0; sw4 = '0;
        data8 = '0; valid8 = 1'b0; sw8 = '0;
        model_reset();
        #12;
        check("rst_addr4", int'(addr4), 0);
        check("rst_led4", int'(led4), 0);
        check("rst_halted4", int'(halted4), 0);
        check("rst_carry4", int'(carry4), 0);
        check("rst_addr8", int'(addr8), 0);
        check("rst_led8", int'(led8), 0);
        n_reset = 1'b1;
        @(posedge clk);
        #1;

        // Overflow to zero, JNC falls through, OUT IMM, HLT.
        step(0, 4'h3, 4'hF, 1, 0);
        step(0, 4'h0, 4'h1, 1, 0);
        check("t1_add_carry", int'(carry4), 1);
        step(0, 4'hE, 4'h0, 1, 0);
        check("t1_jnc_fall", int'(addr4), 3);
        step(0, 4'hB, 4'h5, 1, 0);
        check("t1_led", int'(led4), 5);
        step(0, 4'hD, 4'h0, 1, 0);
        check("t1_halted", int'(halted4), 1);
        for (int i = 0; i < 12; i++)
            step(0, int'($urandom_range(15)), int'($urandom_range(15)), 1, 0);
        check("t1_halt_addr", int'(addr4), 4);
        check("t1_halt_led", int'(led4), 5);

        // Asynchronous reset between edges while halted.
        #3;
        n_reset = 1'b0;
        #1;
        check("arst_addr", int'(addr4), 0);
        check("arst_led", int'(led4), 0);
        check("arst_halted", int'(halted4), 0);
        model_reset();
        @(posedge clk);
        #1;
        n_reset = 1'b1;

        // Restart from 0, IN B / ADD A,B with carry, 3-cycle stall, OUT B.
        step(0, 4'h3, 4'h7, 1, 0);
        check("rst_restart", int'(addr4), 1);
        step(0, 4'h6, 4'h0, 1, 4'hA);
        step(0, 4'h8, 4'h0, 1, 0);
        check("t5_add_carry", int'(carry4), 1);
        for (int i = 0; i < 3; i++)
            step(0, 4'hD, 4'h0, 0, 4'h3);
        check("stall_addr", int'(addr4), 3);
        check("stall_carry", int'(carry4), 1);
        check("stall_halted", int'(halted4), 0);
        step(0, 4'h9, 4'h0, 1, 0);
        check("t5_led_b", int'(led4), 4'hA);
        step(0, 4'h4, 4'h0, 1, 0);
        step(0, 4'h9, 4'h0, 1, 0);
        check("t5_led_a", int'(led4), 1);

        // Wide core: SUB to zero, JZ to the last address, wrap to 0.
        step(1, 4'h3, 8'h10, 1, 0);
        step(1, 4'hA, 8'h10, 1, 0);
        check("t2_sub_carry", int'(carry8), 0);
        step(1, 4'hC, 8'h3F, 1, 0);
        check("t2_jz_taken", int'(addr8), 8'h3F);
        step(1, 4'h7, 8'h00, 1, 0);
        check("t2_wrap", int'(addr8), 0);

        // Borrow, MOV B,A clears carry, JZ not taken, OUT B.
        step(1, 4'h3, 8'h05, 1, 0);
        step(1, 4'hA, 8'h06, 1, 0);
        check("t3_borrow", int'(carry8), 1);
        step(1, 4'h4, 8'h00, 1, 0);
        check("t3_mov_clr", int'(carry8), 0);
        step(1, 4'hC, 8'h00, 1, 0);
        check("t3_jz_fall", int'(addr8), 4);
        step(1, 4'h9, 8'h00, 1, 0);
        check("t3_led", int'(led8), 8'hFF);

        // ADD B,IMM carry, JNC not taken, IN A, JMP with upper imm bits.
        step(1, 4'h7, 8'h80, 1, 0);
        step(1, 4'h5, 8'h80, 1, 0);
        step(1, 4'hE, 8'h10, 1, 0);
        step(1, 4'h1, 8'h00, 1, 0);
        step(1, 4'h2, 8'h00, 1, 8'h3C);
        step(1, 4'h4, 8'h00, 1, 0);
        step(1, 4'h9, 8'h00, 1, 0);
        check("t6_led_sw", int'(led8), 8'h3C);
        step(1, 4'hF, 8'hE5, 1, 0);
        check("t6_jmp", int'(addr8), 8'h25);
        step(1, 4'hE, 8'h30, 1, 0);
        step(1, 4'hD, 8'h00, 1, 0);
        for (int i = 0; i < 4; i++)
            step(1, int'($urandom_range(15)), int'($urandom_range(255)), 1, 0);
        check("t6_halt_addr", int'(addr8), 8'h30);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
